// File: rtl/fixed_point_to_decimal.sv
// Sequential sign-magnitude fixed-point to BCD converter: double dabble for the
// integer part (one bit per cycle), repeated x10 for the fraction (one digit per cycle).
module fixed_point_to_decimal #(
   parameter int INT_WIDTH   = 15,
   parameter int FRAC_WIDTH  = 16,
   parameter int INT_DIGITS  = 5,
   parameter int FRAC_DIGITS = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [INT_WIDTH+FRAC_WIDTH:0]   fixed_point_value,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            sign,
   output logic [4*INT_DIGITS-1:0]         int_bcd,
   output logic [4*FRAC_DIGITS-1:0]        frac_bcd
);

   localparam int W       = 1 + INT_WIDTH + FRAC_WIDTH;
   localparam int CNT_MAX = (INT_WIDTH > FRAC_DIGITS) ? INT_WIDTH : FRAC_DIGITS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_INT, S_FRAC, S_DONE} state_e;

   state_e                   state_q, state_d;
   logic                     sign_q, sign_d;
   logic [INT_WIDTH-1:0]     int_sr_q, int_sr_d;
   logic [FRAC_WIDTH-1:0]    frac_q, frac_d;
   logic [4*INT_DIGITS-1:0]  int_bcd_q, int_bcd_d;
   logic [4*FRAC_DIGITS-1:0] frac_bcd_q, frac_bcd_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;

   logic [4*INT_DIGITS-1:0]  bcd_adj;
   logic [FRAC_WIDTH+3:0]    frac_x10;

   // Add-3 correction so each nibble stays a valid BCD digit after the next shift.
   always_comb begin
      bcd_adj = int_bcd_q;
      for (int i = 0; i < INT_DIGITS; i++) begin
         if (int_bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = int_bcd_q[4*i +: 4] + 4'd3;
      end
   end

   assign frac_x10 = ({4'b0, frac_q} << 3) + ({4'b0, frac_q} << 1);

   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      state_d    = state_q;
      sign_d     = sign_q;
      int_sr_d   = int_sr_q;
      frac_d     = frac_q;
      int_bcd_d  = int_bcd_q;
      frac_bcd_d = frac_bcd_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d    = S_INT;
               // Negative zero is reported as positive.
               sign_d     = fixed_point_value[W-1] & (|fixed_point_value[W-2:0]);
               int_sr_d   = fixed_point_value[W-2:FRAC_WIDTH];
               frac_d     = fixed_point_value[FRAC_WIDTH-1:0];
               int_bcd_d  = '0;
               frac_bcd_d = '0;
               cnt_d      = CNT_W'(INT_WIDTH);
            end
         end
         S_INT: begin
            {int_bcd_d, int_sr_d} = {bcd_adj, int_sr_q} << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FRAC;
               cnt_d   = CNT_W'(FRAC_DIGITS);
            end
         end
         S_FRAC: begin
            frac_bcd_d = (frac_bcd_q << 4)
                       | (4*FRAC_DIGITS)'(frac_x10[FRAC_WIDTH+3:FRAC_WIDTH]);
            frac_d     = frac_x10[FRAC_WIDTH-1:0];
            cnt_d      = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
               state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         sign_q     <= 1'b0;
         int_sr_q   <= '0;
         frac_q     <= '0;
         int_bcd_q  <= '0;
         frac_bcd_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         sign_q     <= sign_d;
         int_sr_q   <= int_sr_d;
         frac_q     <= frac_d;
         int_bcd_q  <= int_bcd_d;
         frac_bcd_q <= frac_bcd_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign sign      = sign_q;
   assign int_bcd   = int_bcd_q;
   assign frac_bcd  = frac_bcd_q;

endmodule

// File: tb/tb_fixed_point_to_decimal.sv
// Scoreboard bench for fixed_point_to_decimal: a driver pushes reference results,
// monitors pop and compare whenever a DUT presents a result.
module tb_fixed_point_to_decimal;

   localparam int LAT = 19;

   typedef struct packed {
      logic        s;
      logic [19:0] ib;
      logic [23:0] fb;
      int unsigned cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] fixed_point_value = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, out_valid, sign;
   logic        out_ready = 1'b1;
   logic [19:0] int_bcd;
   logic [15:0] frac_bcd;

   logic [31:0] fpv6 = '0;
   logic        in_valid6 = 1'b0;
   logic        in_ready6, out_valid6, sign6;
   logic        out_ready6 = 1'b1;
   logic [19:0] int_bcd6;
   logic [23:0] frac_bcd6;

   int unsigned n_checks = 0;
   int unsigned n_bad    = 0;
   int unsigned cyc      = 0;
   bit          bp_hold    = 1'b0;
   bit          rand_ready = 1'b0;
   bit          after_pop  = 1'b0;
   bit          prev_ov    = 1'b0;
   int          w;
   exp_t        q[$];
   exp_t        q6[$];

   fixed_point_to_decimal dut (
      .clock(clock), .reset(reset), .fixed_point_value(fixed_point_value),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .sign(sign), .int_bcd(int_bcd), .frac_bcd(frac_bcd)
   );

   fixed_point_to_decimal #(.FRAC_DIGITS(6)) dut6 (
      .clock(clock), .reset(reset), .fixed_point_value(fpv6),
      .in_valid(in_valid6), .in_ready(in_ready6), .out_valid(out_valid6),
      .out_ready(out_ready6), .sign(sign6), .int_bcd(int_bcd6), .frac_bcd(frac_bcd6)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference: decimal digits by plain division; fraction = floor(f * 10^nd / 2^16).
   function automatic exp_t model(input logic [31:0] v, input int nd);
      exp_t            e;
      int unsigned     ip;
      longint unsigned fs, p10;
      e    = '0;
      e.s  = v[31] && (v[30:0] != 31'd0);
      ip   = 32'(v[30:16]);
      for (int i = 0; i < 5; i++) begin
         e.ib[4*i +: 4] = 4'(ip % 10);
         ip = ip / 10;
      end
      p10 = 1;
      for (int i = 0; i < nd; i++) p10 = p10 * 10;
      fs = (64'(v[15:0]) * p10) >> 16;
      for (int i = 0; i < nd; i++) begin
         e.fb[4*i +: 4] = 4'(fs % 10);
         fs = fs / 10;
      end
      return e;
   endfunction

   task automatic send(input logic [31:0] v);
      exp_t e;
      int   n = 0;
      @(posedge clock);
      #1;
      fixed_point_value = v;
      in_valid = 1'b1;
      forever begin
         @(negedge clock);
         if (in_ready && !reset) break;
         n++;
         if (n > 300) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
            return;
         end
      end
      e     = model(v, 4);
      e.cyc = cyc + 1;
      q.push_back(e);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      fixed_point_value = $urandom;
   endtask

   task automatic send6(input logic [31:0] v);
      int n = 0;
      @(posedge clock);
      #1;
      fpv6 = v;
      in_valid6 = 1'b1;
      forever begin
         @(negedge clock);
         if (in_ready6 && !reset) break;
         n++;
         if (n > 300) begin
            fail_now("send6_timeout");
            in_valid6 = 1'b0;
            return;
         end
      end
      q6.push_back(model(v, 6));
      @(posedge clock);
      #1;
      in_valid6 = 1'b0;
      fpv6 = $urandom;
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (bp_hold)         out_ready = 1'b0;
         else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
         else                 out_ready = 1'b1;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            after_pop = 1'b0;
            prev_ov   = 1'b0;
         end else begin
            if (after_pop) begin
               check("in_ready_after_release", 64'(in_ready), 64'(1));
               check("out_valid_after_release", 64'(out_valid), 64'(0));
               after_pop = 1'b0;
            end
            if (out_valid) begin
               check("in_ready_in_done", 64'(in_ready), 64'(0));
               if (q.size() == 0) begin
                  fail_now("unexpected_result");
               end else begin
                  e = q[0];
                  if (!prev_ov) check("latency", 64'(cyc - e.cyc), 64'(LAT));
                  check("sign", 64'(sign), 64'(e.s));
                  check("int_bcd", 64'(int_bcd), 64'(e.ib));
                  check("frac_bcd", 64'(frac_bcd), 64'(e.fb[15:0]));
                  if (out_ready) begin
                     void'(q.pop_front());
                     after_pop = 1'b1;
                  end
               end
            end
            prev_ov = out_valid;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && out_valid6 && out_ready6) begin
            if (q6.size() == 0) begin
               fail_now("unexpected_result6");
            end else begin
               e = q6.pop_front();
               check("sign6", 64'(sign6), 64'(e.s));
               check("int_bcd6", 64'(int_bcd6), 64'(e.ib));
               check("frac_bcd6", 64'(frac_bcd6), 64'(e.fb));
            end
         end
      end
   end

   initial begin
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_outputs", 64'({sign, int_bcd, frac_bcd}), 64'(0));
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;

      // Directed vectors, including truncation and negative zero.
      send(32'h0001_8000);
      send(32'h7FFF_FFFF);
      send(32'h8003_4000);
      send(32'h8000_0000);
      send(32'h0000_0CCD);
      send(32'h0000_0001);
      send(32'hFFFF_0000);

      // Six-digit fraction instance.
      send6(32'h0000_0001);
      send6(32'h7FFF_FFFF);
      send6(32'h8000_0000);
      for (int i = 0; i < 4; i++) send6($urandom);

      // Backpressure: result held for 10 cycles while a new word waits on in_valid.
      bp_hold = 1'b1;
      send(32'h0005_2000);
      fork
         send(32'h0002_C000);
         begin
            w = 0;
            while (!out_valid && w < 100) begin
               @(negedge clock);
               w++;
            end
            if (!out_valid) fail_now("bp_wait_timeout");
            repeat (10) @(posedge clock);
            bp_hold = 1'b0;
         end
      join

      // Asynchronous reset 7 cycles into a conversion.
      send(32'h1234_5678);
      repeat (7) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      check("midrst_outputs", 64'({sign, int_bcd, frac_bcd}), 64'(0));
      q.delete();
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      send(32'h8003_4000);

      // Random words with random consumer stalls.
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) send($urandom);
      rand_ready = 1'b0;

      w = 0;
      while ((q.size() != 0 || q6.size() != 0) && w < 500) begin
         @(posedge clock);
         w++;
      end
      if (q.size() != 0 || q6.size() != 0) fail_now("drain_timeout");
      repeat (2) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_bad);
      $finish;
   end

endmodule
